// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: state encodings,
// oversampling defaults, majority-sample offsets and the data-width clamp.
package uart_rx_cfg_pkg;

    localparam int OSR_DEFAULT = 16;
    localparam int DBIT_MIN    = 5;
    localparam int VOTE_PRE    = 1;
    localparam int VOTE_POST   = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    // Out-of-range requests saturate to the nearest supported width.
    function automatic logic [3:0] clamp_dbits(input logic [3:0] cfg, input int dmax);
        logic [3:0] res;
        if (int'(cfg) < DBIT_MIN) begin
            res = 4'(DBIT_MIN);
        end else if (int'(cfg) > dmax) begin
            res = 4'(dmax);
        end else begin
            res = cfg;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_sync_vote.sv
// rx synchroniser chain plus the 3-sample majority voter; the third sample is
// taken combinationally so the vote is usable in the same cycle as its tick.
module uart_rx_cfg_sync_vote
    import uart_rx_cfg_pkg::*;
#(
    parameter int OSR         = OSR_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = $clog2(OSR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    input  logic          s_tick,
    input  logic [CW-1:0] s_cnt,
    output logic          rxs,
    output logic          vote,
    output logic          vote_stb
);

    localparam logic [CW-1:0] SMP0 = CW'(OSR / 2 - VOTE_PRE);
    localparam logic [CW-1:0] SMP1 = CW'(OSR / 2);
    localparam logic [CW-1:0] SMP2 = CW'(OSR / 2 + VOTE_POST);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             smp_q;

    // Preset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= 2'b11;
        end else if (s_tick) begin
            if (s_cnt == SMP0) smp_q[0] <= rxs;
            if (s_cnt == SMP1) smp_q[1] <= rxs;
        end
    end

    assign vote_stb = s_tick && (s_cnt == SMP2);
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with valid/ready output, framing, overrun
// and break detection. Define UART_RX_PARITY_EN to build the parity stage.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int DBIT_MAX    = 9,
    parameter int OSR         = OSR_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx,
    input  logic                s_tick,
    input  logic [3:0]          cfg_dbits,
    input  logic                cfg_stop2,
    input  logic                cfg_par_en,
    input  logic                cfg_par_odd,
    output logic [DBIT_MAX-1:0] m_data,
    output logic                m_err_frame,
    output logic                m_err_par,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                overrun,
    output logic                break_det,
    output logic                busy
);

    localparam int CW = $clog2(OSR);
    localparam int NW = $clog2(DBIT_MAX);
    localparam logic [CW-1:0] S_LAST  = CW'(OSR - 1);
    localparam logic [NW-1:0] N_WIDEST = NW'(DBIT_MAX - 1);

    rx_state_t            state, state_nxt;
    logic [1:0]           rst_q;
    logic                 rst_n;
    logic                 rxs, vote, vote_stb;
    logic [CW-1:0]        s_cnt;
    logic [NW-1:0]        n, dbits_m1;
    logic [DBIT_MAX-1:0]  b_reg;
    logic                 stop2_q, stop_idx, err_frame_q;
    logic                 par_go, par_zero;
    logic                 start_det, bit_end, last_data, last_stop, brk_cond;
    logic                 deliver, brk_stb, load_ok, drop;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_q <= 2'b00;
        end else begin
            rst_q <= {rst_q[0], 1'b1};
        end
    end

    assign rst_n = rst_q[1];

    uart_rx_cfg_sync_vote #(
        .OSR         (OSR),
        .SYNC_STAGES (SYNC_STAGES),
        .CW          (CW)
    ) u_sync_vote (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .s_tick   (s_tick),
        .s_cnt    (s_cnt),
        .rxs      (rxs),
        .vote     (vote),
        .vote_stb (vote_stb)
    );

    assign start_det = (state == IDLE) && s_tick && !rxs;
    assign bit_end   = s_tick && (s_cnt == S_LAST);
    assign last_data = (n == dbits_m1);
    assign last_stop = (stop_idx == stop2_q);
    assign brk_cond  = !stop_idx && !vote && (b_reg == '0) && par_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A break ends the frame at its first stop vote even when two stop bits are configured.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_det) state_nxt = START;
            START: begin
                if (vote_stb && vote) begin
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA:     if (bit_end && last_data) state_nxt = par_go ? PARITY : STOP;
`ifdef UART_RX_PARITY_EN
            PARITY:   if (bit_end) state_nxt = STOP;
`endif
            STOP: begin
                if (vote_stb) begin
                    if (brk_cond) begin
                        state_nxt = BRK_WAIT;
                    end else if (last_stop) begin
                        state_nxt = IDLE;
                    end
                end
            end
            BRK_WAIT: if (rxs) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        deliver = 1'b0;
        brk_stb = 1'b0;
        if ((state == STOP) && vote_stb) begin
            brk_stb = brk_cond;
            deliver = brk_cond || last_stop;
        end
        load_ok = deliver && (!m_valid || m_ready);
        drop    = deliver && m_valid && !m_ready;
    end

    // Frame configuration is captured at the start edge and held for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt       <= '0;
            n           <= '0;
            b_reg       <= '0;
            dbits_m1    <= '0;
            stop2_q     <= 1'b0;
            stop_idx    <= 1'b0;
            err_frame_q <= 1'b0;
        end else if (start_det) begin
            s_cnt       <= '0;
            n           <= '0;
            b_reg       <= '0;
            dbits_m1    <= NW'(clamp_dbits(cfg_dbits, DBIT_MAX) - 4'd1);
            stop2_q     <= cfg_stop2;
            stop_idx    <= 1'b0;
            err_frame_q <= 1'b0;
        end else if ((state != IDLE) && (state != BRK_WAIT)) begin
            if (s_tick) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + CW'(1);
            end
            case (state)
                DATA: begin
                    if (vote_stb) b_reg <= {vote, b_reg[DBIT_MAX-1:1]};
                    if (bit_end)  n     <= n + NW'(1);
                end
                STOP: begin
                    if (vote_stb && !vote) err_frame_q <= 1'b1;
                    if (bit_end)           stop_idx    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Dropped words leave the held word untouched; only the overrun pulse reports them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data      <= '0;
            m_err_frame <= 1'b0;
            m_valid     <= 1'b0;
            overrun     <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            overrun   <= drop;
            break_det <= brk_stb;
            if (load_ok) begin
                m_data      <= b_reg >> (N_WIDEST - dbits_m1);
                m_err_frame <= err_frame_q | !vote;
                m_valid     <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_odd_q, err_par_q;

    // par_zero remembers a 0 parity bit so an all-zero frame can still be classed as a break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            err_par_q <= 1'b0;
            par_zero  <= 1'b1;
            m_err_par <= 1'b0;
        end else begin
            if (start_det) begin
                par_en_q  <= cfg_par_en;
                par_odd_q <= cfg_par_odd;
                err_par_q <= 1'b0;
                par_zero  <= 1'b1;
            end else if ((state == PARITY) && vote_stb) begin
                err_par_q <= ((^b_reg) ^ vote) != par_odd_q;
                par_zero  <= !vote;
            end
            if (load_ok) m_err_par <= err_par_q;
        end
    end

    assign par_go = par_en_q;
`else
    logic unused_par;

    assign unused_par = cfg_par_en ^ cfg_par_odd;
    assign par_go     = 1'b0;
    assign par_zero   = 1'b1;
    assign m_err_par  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames push expected words, a
// negedge monitor pops and compares every accepted word.
module tb_uart_rx_cfg;

    localparam int OSR          = 16;
    localparam int CLK_PER_TICK = 4;

    typedef struct packed {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n, rx, s_tick, m_ready;
    logic [3:0] cfg_dbits;
    logic       cfg_stop2, cfg_par_en, cfg_par_odd;
    logic [8:0] m_data;
    logic       m_err_frame, m_err_par, m_valid, overrun, break_det, busy;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   valid_cycles = 0;
    int   overrun_cnt = 0;
    int   break_cnt = 0;
    int   snap_v, snap_o, snap_b;

    uart_rx_cfg #(
        .DBIT_MAX    (9),
        .OSR         (OSR),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .s_tick      (s_tick),
        .cfg_dbits   (cfg_dbits),
        .cfg_stop2   (cfg_stop2),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .m_data      (m_data),
        .m_err_frame (m_err_frame),
        .m_err_par   (m_err_par),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .overrun     (overrun),
        .break_det   (break_det),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (CLK_PER_TICK - 1) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Words are checked at the moment the consumer accepts them.
    always @(negedge clk) begin
        if (m_valid)   valid_cycles++;
        if (overrun)   overrun_cnt++;
        if (break_det) break_cnt++;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", int'(m_data), -1);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("m_data", int'(m_data), int'(mon_e.data));
                checkOutput("m_err_frame", int'(m_err_frame), int'(mon_e.ferr));
                checkOutput("m_err_par", int'(m_err_par), int'(mon_e.perr));
            end
        end
    end

    task automatic pushExp(input logic [8:0] data, input logic ferr, input logic perr);
        exp_t e;
        e.data = data;
        e.ferr = ferr;
        e.perr = perr;
        exp_q.push_back(e);
    endtask

    task automatic holdBit(input logic v, input int ticks);
        @(posedge clk);
        #1 rx = v;
        repeat (ticks * CLK_PER_TICK - 1) @(posedge clk);
    endtask

    // par_bit < 0 means no parity bit; glitch_bit inverts one tick in the middle of that data bit.
    task automatic applyStimulus(input logic [8:0] data, input int nbits, input int par_bit,
                                 input int nstop, input logic stop_val, input int glitch_bit);
        holdBit(1'b0, OSR);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_bit) begin
                holdBit(data[i], 8);
                holdBit(~data[i], 1);
                holdBit(data[i], 7);
            end else begin
                holdBit(data[i], OSR);
            end
        end
        if (par_bit >= 0) holdBit(par_bit[0], OSR);
        for (int i = 0; i < nstop; i++) holdBit((i == 0) ? stop_val : 1'b1, OSR);
        holdBit(1'b1, OSR);
    endtask

    initial begin
        reset_n     = 1'b0;
        rx          = 1'b1;
        cfg_dbits   = 4'd8;
        cfg_stop2   = 1'b0;
        cfg_par_en  = 1'b0;
        cfg_par_odd = 1'b0;
        m_ready     = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_m_valid", int'(m_valid), 0);
        checkOutput("rst_m_data", int'(m_data), 0);
        checkOutput("rst_err_frame", int'(m_err_frame), 0);
        checkOutput("rst_err_par", int'(m_err_par), 0);
        checkOutput("rst_pulses", int'({overrun, break_det}), 0);
        checkOutput("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        $display("[TB] 8N1 0xA5");
        snap_v = valid_cycles;
        pushExp(9'h0A5, 1'b0, 1'b0);
        applyStimulus(9'h0A5, 8, -1, 1, 1'b1, -1);
        checkOutput("a5_drained", exp_q.size(), 0);
        checkOutput("a5_valid_cycles", valid_cycles - snap_v, 1);
        checkOutput("a5_busy_idle", int'(busy), 0);

        $display("[TB] width clamp");
        cfg_dbits = 4'd3;
        pushExp(9'h015, 1'b0, 1'b0);
        applyStimulus(9'h015, 5, -1, 1, 1'b1, -1);
        cfg_dbits = 4'd15;
        pushExp(9'h1A5, 1'b0, 1'b0);
        applyStimulus(9'h1A5, 9, -1, 1, 1'b1, -1);
        checkOutput("clamp_drained", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        $display("[TB] 7E2 / 7O2 parity");
        cfg_dbits  = 4'd7;
        cfg_stop2  = 1'b1;
        cfg_par_en = 1'b1;
        pushExp(9'h041, 1'b0, 1'b0);
        applyStimulus(9'h041, 7, 0, 2, 1'b1, -1);
        pushExp(9'h041, 1'b0, 1'b1);
        applyStimulus(9'h041, 7, 1, 2, 1'b1, -1);
        cfg_par_odd = 1'b1;
        pushExp(9'h041, 1'b0, 1'b0);
        applyStimulus(9'h041, 7, 1, 2, 1'b1, -1);
        cfg_par_en  = 1'b0;
        cfg_par_odd = 1'b0;
`else
        $display("[TB] 7N2");
        cfg_dbits  = 4'd7;
        cfg_stop2  = 1'b1;
        cfg_par_en = 1'b1;
        pushExp(9'h041, 1'b0, 1'b0);
        applyStimulus(9'h041, 7, -1, 2, 1'b1, -1);
        cfg_par_en = 1'b0;
`endif
        checkOutput("dbits7_drained", exp_q.size(), 0);

        $display("[TB] framing error");
        cfg_dbits = 4'd8;
        cfg_stop2 = 1'b0;
        snap_b    = break_cnt;
        pushExp(9'h081, 1'b1, 1'b0);
        applyStimulus(9'h081, 8, -1, 1, 1'b0, -1);
        holdBit(1'b1, OSR);
        checkOutput("ferr_drained", exp_q.size(), 0);
        checkOutput("ferr_no_break", break_cnt - snap_b, 0);

        $display("[TB] glitches");
        snap_v = valid_cycles;
        pushExp(9'h03C, 1'b0, 1'b0);
        applyStimulus(9'h03C, 8, -1, 1, 1'b1, 2);
        holdBit(1'b0, 6);
        holdBit(1'b1, 2 * OSR);
        checkOutput("glitch_drained", exp_q.size(), 0);
        checkOutput("glitch_words", valid_cycles - snap_v, 1);
        checkOutput("glitch_busy_idle", int'(busy), 0);

        $display("[TB] overrun");
        m_ready = 1'b0;
        pushExp(9'h011, 1'b0, 1'b0);
        applyStimulus(9'h011, 8, -1, 1, 1'b1, -1);
        snap_o = overrun_cnt;
        applyStimulus(9'h022, 8, -1, 1, 1'b1, -1);
        checkOutput("ovr_pulses", overrun_cnt - snap_o, 1);
        checkOutput("ovr_held_valid", int'(m_valid), 1);
        checkOutput("ovr_held_data", int'(m_data), 'h011);
        @(posedge clk);
        #1 m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("ovr_drained", exp_q.size(), 0);
        checkOutput("ovr_valid_low", int'(m_valid), 0);

        $display("[TB] break");
        snap_b = break_cnt;
        pushExp(9'h000, 1'b1, 1'b0);
        holdBit(1'b0, 30 * OSR);
        checkOutput("brk_pulses", break_cnt - snap_b, 1);
        checkOutput("brk_drained", exp_q.size(), 0);
        checkOutput("brk_wait_busy", int'(busy), 1);
        holdBit(1'b1, 2 * OSR);
        checkOutput("brk_release_idle", int'(busy), 0);
        pushExp(9'h055, 1'b0, 1'b0);
        applyStimulus(9'h055, 8, -1, 1, 1'b1, -1);
        checkOutput("brk_next_drained", exp_q.size(), 0);

        $display("[TB] reset mid-frame");
        holdBit(1'b0, OSR);
        holdBit(1'b1, OSR);
        holdBit(1'b0, OSR);
        checkOutput("mid_busy", int'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_valid", int'(m_valid), 0);
        rx     = 1'b1;
        snap_o = overrun_cnt;
        snap_b = break_cnt;
        snap_v = valid_cycles;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        pushExp(9'h07E, 1'b0, 1'b0);
        applyStimulus(9'h07E, 8, -1, 1, 1'b1, -1);
        checkOutput("post_rst_drained", exp_q.size(), 0);
        checkOutput("post_rst_words", valid_cycles - snap_v, 1);
        checkOutput("post_rst_pulses", (overrun_cnt - snap_o) + (break_cnt - snap_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
